periph_init_seq: RTL and testbench

- Parametrised bring-up and register-access sequencer for NUM_DEV I2C-configured peripherals, e.g. ADV7513 HDMI-TX plus camera sensors.
- After a power-on delay it initialises each device in index order using start/done handshakes, with per-device timeout and retry.
- It then arbitrates single register-read requests to a selected device.
- It sits at the top level between the user controls (key, switch) and the per-device init/reg_read engines.
- All timing is derived from a 1 us tick generated inside the block from clk, so no second clock domain is needed.

---
 rtl/periph_seq_pkg.sv | 24 ++
 rtl/us_tick_gen.sv | 27 ++
 rtl/periph_init_seq.sv | 198 +++++++++++++++++++
 tb/tb_periph_init_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_seq_pkg.sv
// Shared state codes and helpers for the peripheral bring-up sequencer.
// State codes are also decoded by the 7-seg status logic, so their values are fixed.
package periph_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_STARTUP    = 4'd1,
    ST_INIT_START = 4'd2,
    ST_INIT_WAIT  = 4'd3,
    ST_RD_START   = 4'd4,
    ST_RD_WAIT    = 4'd5,
    ST_INIT_NEXT  = 4'd6
  } seq_state_e;

  localparam int unsigned STATE_W = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned p = 1; p < value; p = p << 1) res++;
    return res;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_DIV clocks.
module us_tick_gen
  import periph_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned PW = clog2(CLK_DIV);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(CLK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

endmodule

// File: rtl/periph_init_seq.sv
// Power-on bring-up of NUM_DEV peripherals with timeout/retry, followed by
// arbitration of single register reads; all delays are counted in 1 us ticks.
module periph_init_seq
  import periph_seq_pkg::*;
#(
  parameter int unsigned NUM_DEV         = 2,
  parameter int unsigned DEV_W           = 3,
  parameter int unsigned CLK_DIV         = 50,
  parameter int unsigned DLY_W           = 24,
  parameter int unsigned STARTUP_US      = 1000000,
  parameter int unsigned INIT_TIMEOUT_US = 1000000,
  parameter int unsigned TXN_TIMEOUT_US  = 600,
  parameter int unsigned MAX_RETRY       = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [NUM_DEV-1:0] init_start,
  input  logic [NUM_DEV-1:0] init_done,
  input  logic               rd_req,
  input  logic [DEV_W-1:0]   rd_dev,
  output logic [NUM_DEV-1:0] rd_start,
  input  logic [NUM_DEV-1:0] rd_done,
  output logic               rd_busy,
  output logic               rd_ack,
  output logic               rd_err,
  output logic [NUM_DEV-1:0] init_ok,
  output logic [NUM_DEV-1:0] init_fail,
  output logic               all_ready,
  output logic [3:0]         state_o,
  output logic [DEV_W-1:0]   cur_dev
);

  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : clog2(MAX_RETRY + 1);

  seq_state_e         state_q, state_d;
  logic [DEV_W-1:0]   dev_q, dev_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [NUM_DEV-1:0] init_ok_q, init_ok_d;
  logic [NUM_DEV-1:0] init_fail_q, init_fail_d;
  logic [NUM_DEV-1:0] init_start_q, init_start_d;
  logic [NUM_DEV-1:0] rd_start_q, rd_start_d;
  logic [NUM_DEV-1:0] init_done_q, rd_done_q;
  logic               rd_busy_q, rd_busy_d;
  logic               rd_ack_q, rd_ack_d;
  logic               rd_err_q, rd_err_d;
  logic [STATE_W-1:0] state_o_q;
  logic [NUM_DEV-1:0] dev_oh, req_oh;
  logic               init_rise, rd_rise, req_ok, tick;

  us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    dev_oh = '0;
    req_oh = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      dev_oh[i] = (dev_q == DEV_W'(i));
      req_oh[i] = (rd_dev == DEV_W'(i));
    end
  end

  // Out-of-range rd_dev yields an all-zero req_oh and is rejected like a non-ready device.
  assign req_ok    = |(init_ok_q & req_oh);
  assign init_rise = |(init_done & ~init_done_q & dev_oh);
  assign rd_rise   = |(rd_done & ~rd_done_q & dev_oh);

  always_comb begin
    state_d      = state_q;
    dev_d        = dev_q;
    retry_d      = retry_q;
    init_ok_d    = init_ok_q;
    init_fail_d  = init_fail_q;
    init_start_d = '0;
    rd_start_d   = '0;
    rd_busy_d    = rd_busy_q;
    rd_ack_d     = 1'b0;
    rd_err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          if (req_ok) begin
            dev_d     = rd_dev;
            rd_busy_d = 1'b1;
            state_d   = ST_RD_START;
          end else begin
            rd_err_d = 1'b1;
          end
        end
      end
      ST_STARTUP: begin
        if (cnt_q == DLY_W'(STARTUP_US)) state_d = ST_INIT_START;
      end
      ST_INIT_START: begin
        init_start_d = dev_oh;
        state_d      = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (init_rise) begin
          init_ok_d = init_ok_q | dev_oh;
          retry_d   = '0;
          state_d   = ST_INIT_NEXT;
        end else if (cnt_q == DLY_W'(INIT_TIMEOUT_US)) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_INIT_START;
          end else begin
            // Retry count also clears here so the next device gets its full budget.
            init_fail_d = init_fail_q | dev_oh;
            retry_d     = '0;
            state_d     = ST_INIT_NEXT;
          end
        end
      end
      ST_INIT_NEXT: begin
        if (dev_q == DEV_W'(NUM_DEV - 1)) begin
          dev_d   = '0;
          state_d = ST_IDLE;
        end else begin
          dev_d   = dev_q + 1'b1;
          state_d = ST_INIT_START;
        end
      end
      ST_RD_START: begin
        rd_start_d = dev_oh;
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_rise) begin
          rd_ack_d  = 1'b1;
          rd_busy_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_q == DLY_W'(TXN_TIMEOUT_US)) begin
          rd_err_d  = 1'b1;
          rd_busy_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_comb begin
    if (state_d != state_q)        cnt_d = '0;
    else if (tick && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
    else                           cnt_d = cnt_q;
  end

  // state_o is a registered copy of the next state so it reads 0 while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_STARTUP;
      dev_q        <= '0;
      retry_q      <= '0;
      cnt_q        <= '0;
      init_ok_q    <= '0;
      init_fail_q  <= '0;
      init_start_q <= '0;
      rd_start_q   <= '0;
      init_done_q  <= '0;
      rd_done_q    <= '0;
      rd_busy_q    <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      state_o_q    <= '0;
    end else begin
      state_q      <= state_d;
      dev_q        <= dev_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      init_ok_q    <= init_ok_d;
      init_fail_q  <= init_fail_d;
      init_start_q <= init_start_d;
      rd_start_q   <= rd_start_d;
      init_done_q  <= init_done;
      rd_done_q    <= rd_done;
      rd_busy_q    <= rd_busy_d;
      rd_ack_q     <= rd_ack_d;
      rd_err_q     <= rd_err_d;
      state_o_q    <= state_d;
    end
  end

  assign init_start = init_start_q;
  assign rd_start   = rd_start_q;
  assign rd_busy    = rd_busy_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
  assign init_ok    = init_ok_q;
  assign init_fail  = init_fail_q;
  assign all_ready  = (state_q == ST_IDLE) & (&init_ok_q);
  assign state_o    = state_o_q;
  assign cur_dev    = dev_q;

endmodule

// File: tb/tb_periph_init_seq.sv
// Directed bench for periph_init_seq; cycle numbers count negedges after the
// last clock edge that sampled reset high (ticks land on edges that are multiples of 4).
module tb_periph_init_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] init_start, init_done, rd_start, rd_done, init_ok, init_fail;
  logic       rd_req, rd_busy, rd_ack, rd_err, all_ready;
  logic [2:0] rd_dev, cur_dev;
  logic [3:0] state_o;

  int n_total = 0;
  int n_bad   = 0;
  int n       = 0;
  int at;

  periph_init_seq #(
    .NUM_DEV(2), .DEV_W(3), .CLK_DIV(4), .DLY_W(24), .STARTUP_US(10),
    .INIT_TIMEOUT_US(20), .TXN_TIMEOUT_US(8), .MAX_RETRY(1)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_done(init_done),
    .rd_req(rd_req), .rd_dev(rd_dev), .rd_start(rd_start), .rd_done(rd_done),
    .rd_busy(rd_busy), .rd_ack(rd_ack), .rd_err(rd_err), .init_ok(init_ok),
    .init_fail(init_fail), .all_ready(all_ready), .state_o(state_o), .cur_dev(cur_dev)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    n++;
  endtask

  task automatic adv_to(input int target);
    while (n < target) adv();
  endtask

  task automatic do_reset();
    reset = 1'b1; init_done = '0; rd_done = '0; rd_req = 1'b0; rd_dev = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
  endtask

  task automatic wait_start(input int limit, output int cyc);
    cyc = -1;
    while (n < limit) begin
      adv();
      if (init_start != 2'b00) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic wait_err(input int limit, output int cyc);
    cyc = -1;
    while (n < limit) begin
      adv();
      if (rd_err) begin
        cyc = n;
        break;
      end
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {init_start, init_fail, init_ok, rd_start, rd_busy, rd_ack, rd_err,
            all_ready, cur_dev, state_o};
  endfunction

  initial begin
    int busy_cnt, ack_cnt, st_at, ack_at, p_cnt, p1, p2;

    // Nominal bring-up
    do_reset();
    chk("rst_outs", all_outs(), 32'd0);
    adv();
    chk("startup_code", state_o, 4'd1);
    wait_start(200, at);
    chk("init0_cycle", at, 42);
    chk("init0_vec", init_start, 2'b01);
    adv();
    chk("init0_len", init_start, 2'b00);
    chk("wait_code", state_o, 4'd3);
    adv_to(62);
    init_done[0] = 1'b1;
    wait_start(200, at);
    chk("init1_cycle", at, 65);
    chk("init1_vec", init_start, 2'b10);
    chk("init1_dev", cur_dev, 3'd1);
    adv_to(85);
    init_done[1] = 1'b1;
    adv();
    chk("next_code", state_o, 4'd6);
    adv();
    chk("boot_ok", init_ok, 2'b11);
    chk("boot_fail", init_fail, 2'b00);
    chk("boot_ready", all_ready, 1'b1);
    chk("boot_state", state_o, 4'd0);
    chk("boot_dev", cur_dev, 3'd0);

    // Read path: rd_req at 87, rd_done[1] rises at 92
    rd_dev = 3'd1; rd_req = 1'b1;
    busy_cnt = 0; ack_cnt = 0; st_at = -1; ack_at = -1;
    for (int i = 1; i <= 8; i++) begin
      adv();
      rd_req = 1'b0;
      if (rd_start != 2'b00) begin
        st_at = n;
        chk("rd_start_vec", rd_start, 2'b10);
      end
      if (rd_busy) busy_cnt++;
      if (rd_ack) begin
        ack_cnt++;
        ack_at = n;
      end
      if (n == 92) rd_done[1] = 1'b1;
    end
    chk("rd_start_cycle", st_at, 89);
    chk("rd_busy_len", busy_cnt, 5);
    chk("rd_ack_cnt", ack_cnt, 1);
    chk("rd_ack_cycle", ack_at, 93);
    rd_done = '0;

    // Rejections
    rd_dev = 3'd3; rd_req = 1'b1;
    adv();
    rd_req = 1'b0;
    chk("rej_range_err", rd_err, 1'b1);
    chk("rej_range_busy", rd_busy, 1'b0);
    adv();
    chk("rej_range_err_len", rd_err, 1'b0);
    chk("rej_range_start", rd_start, 2'b00);
    rd_dev = 3'd0; rd_req = 1'b1;
    adv();
    chk("acc_busy", rd_busy, 1'b1);
    rd_dev = 3'd3;
    adv();
    rd_req = 1'b0;
    chk("busy_ignore_err", rd_err, 1'b0);
    chk("busy_start_vec", rd_start, 2'b01);
    adv();
    rd_done[0] = 1'b1;
    adv();
    chk("dev0_ack", rd_ack, 1'b1);
    chk("dev0_err", rd_err, 1'b0);
    rd_done = '0;

    // Read timeout: request at 103, RD_WAIT from 105, count reaches 8 after edge 136
    adv_to(103);
    rd_dev = 3'd1; rd_req = 1'b1;
    adv();
    rd_req = 1'b0;
    wait_err(300, at);
    chk("to_err_cycle", at, 137);
    chk("to_ack", rd_ack, 1'b0);
    chk("to_busy", rd_busy, 1'b0);

    // Tie: RD_WAIT from 140, timeout edge 173, done rise presented in cycle 172
    adv_to(138);
    rd_req = 1'b1;
    adv();
    rd_req = 1'b0;
    adv_to(141);
    chk("rdwait_code", state_o, 4'd5);
    adv_to(172);
    chk("tie_pre_err", rd_err, 1'b0);
    rd_done[1] = 1'b1;
    adv();
    chk("tie_ack", rd_ack, 1'b1);
    chk("tie_err", rd_err, 1'b0);
    chk("tie_busy", rd_busy, 1'b0);
    rd_done = '0;

    // Retry then fail on dev0
    do_reset();
    p_cnt = 0; p1 = -1; p2 = -1;
    while (n < 203) begin
      adv();
      if (init_start == 2'b01) begin
        p_cnt++;
        if (p_cnt == 1) p1 = n;
        else p2 = n;
      end
    end
    chk("retry_pulses", p_cnt, 2);
    chk("retry_first", p1, 42);
    chk("retry_second", p2, 122);
    chk("fail_next_vec", init_start, 2'b10);
    chk("fail_flag", init_fail, 2'b01);
    adv_to(223);
    init_done[1] = 1'b1;
    adv_to(225);
    chk("mixed_ok", init_ok, 2'b10);
    chk("mixed_fail", init_fail, 2'b01);
    chk("mixed_ready", all_ready, 1'b0);
    chk("mixed_state", state_o, 4'd0);
    rd_dev = 3'd0; rd_req = 1'b1;
    adv();
    rd_req = 1'b0;
    chk("rej_failed_err", rd_err, 1'b1);
    chk("rej_failed_busy", rd_busy, 1'b0);
    adv();
    chk("rej_failed_start", rd_start, 2'b00);

    // Stale done level and mid-operation reset
    do_reset();
    init_done = 2'b01;
    adv_to(100);
    chk("stale_ok", init_ok, 2'b00);
    chk("stale_state", state_o, 4'd3);
    reset = 1'b1;
    adv();
    chk("midrst_outs", all_outs(), 32'd0);
    reset = 1'b0;
    n = 0;
    adv();
    chk("restart_code", state_o, 4'd1);
    wait_start(200, at);
    chk("restart_init0", at, 42);
    adv();
    init_done[0] = 1'b0;
    adv_to(50);
    chk("restart_no_ok", init_ok, 2'b00);
    init_done[0] = 1'b1;
    adv();
    chk("restart_ok", init_ok, 2'b01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", n);
    $fatal(1);
  end

endmodule
